fetch_packer: RTL and testbench

Front-end block that turns raw fetch-group beats (fetch PC, aligned 64-bit instruction pair, per-slot prediction bits) into the 128-bit instruction package consumed by the decode stage. It buffers packages in a small FIFO so fetch can run ahead of a stalled back end. It also applies the PC-alignment and predicted-taken slot-kill rules, so decode only ever sees legal slot-valid combinations.

---
 rtl/fetch_packer.sv | 129 ++++++++++++
 tb/tb_fetch_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_packer.sv
// Packs fetch beats (PC, aligned instruction pair, per-slot prediction) into decode packages and buffers them in a FIFO.
// Optional same-cycle bypass of an empty FIFO is enabled by defining FETCH_PACKER_BYPASS_EN.
module fetch_packer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     fetch_valid_i,
    output logic                     fetch_ready_o,
    input  logic [31:0]              fetch_pc_i,
    input  logic [63:0]              fetch_data_i,
    input  logic [1:0]               pred_br_i,
    input  logic [1:0]               pred_taken_i,
    output logic                     package_valid_o,
    input  logic                     package_ready_i,
    output logic [127:0]             inst_package_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // A predicted-taken low slot kills the high slot; an odd-word PC only carries the high word.
    function automatic logic [127:0] pack_beat(
        input logic [31:0] pc,
        input logic [63:0] data,
        input logic [1:0]  br,
        input logic [1:0]  tk
    );
        logic [31:0] inst1;
        logic [31:0] inst2;
        logic        v2;
        logic        br1;
        logic        tk1;
        logic        br2;
        logic        tk2;
        if (pc[2] == 1'b0) begin
            inst1 = data[31:0];
            br1   = br[0];
            tk1   = br[0] & tk[0];
            v2    = ~tk1;
            br2   = v2 & br[1];
            tk2   = br2 & tk[1];
        end else begin
            inst1 = data[63:32];
            br1   = br[1];
            tk1   = br[1] & tk[1];
            v2    = 1'b0;
            br2   = 1'b0;
            tk2   = 1'b0;
        end
        inst2 = v2 ? data[63:32] : 32'h0000_0000;
        return {pc[31:2], 2'b00, inst1, inst2, 1'b1, v2, br1, tk1, br2, tk2, 26'd0};
    endfunction

    logic [127:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic [127:0]  packed_s;
    logic          have_head_s;
    logic          bypass_s;
    logic          enq_s;
    logic          deq_s;

    assign packed_s    = pack_beat(fetch_pc_i, fetch_data_i, pred_br_i, pred_taken_i);
    assign have_head_s = rst & (count_r != {CW{1'b0}});

`ifdef FETCH_PACKER_BYPASS_EN
    assign bypass_s = rst & fetch_valid_i & ~flush_i & (count_r == {CW{1'b0}});
`else
    assign bypass_s = 1'b0;
`endif

    assign fetch_ready_o = rst & ~flush_i & (count_r < CW'(DEPTH));
    // A bypassed beat taken by decode in the same cycle never occupies an entry.
    assign enq_s         = fetch_valid_i & fetch_ready_o & ~(bypass_s & package_ready_i);
    assign deq_s         = have_head_s & package_ready_i;

    // Output selection: buffered head first, then the bypassed beat, else zero.
    always_comb begin
        package_valid_o = have_head_s | bypass_s;
        inst_package_o  = 128'd0;
        if (have_head_s) begin
            inst_package_o = mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            inst_package_o = packed_s;
        end else begin
            inst_package_o = 128'd0;
        end
    end

    assign fifo_count_o = rst ? count_r : {CW{1'b0}};

    // Entry storage is written only on an accepted beat and never needs clearing.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_r[wr_ptr_r] <= packed_s;
        end
    end

    // Pointer and occupancy tracking; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_packer.sv
// Self-checking bench for fetch_packer: queue-based reference model checked every cycle,
// a table of hand-computed packages, and directed backpressure/flush/reset sequences.
module tb_fetch_packer;

    localparam int DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         flush_i;
    logic         fetch_valid_i;
    logic         fetch_ready_o;
    logic [31:0]  fetch_pc_i;
    logic [63:0]  fetch_data_i;
    logic [1:0]   pred_br_i;
    logic [1:0]   pred_taken_i;
    logic         package_valid_o;
    logic         package_ready_i;
    logic [127:0] inst_package_o;
    logic [2:0]   fifo_count_o;

    fetch_packer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_ready_o   (fetch_ready_o),
        .fetch_pc_i      (fetch_pc_i),
        .fetch_data_i    (fetch_data_i),
        .pred_br_i       (pred_br_i),
        .pred_taken_i    (pred_taken_i),
        .package_valid_o (package_valid_o),
        .package_ready_i (package_ready_i),
        .inst_package_o  (inst_package_o),
        .fifo_count_o    (fifo_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  pc;
        logic [63:0]  data;
        logic [1:0]   br;
        logic [1:0]   tk;
        logic [127:0] exp;
    } vec_t;

    vec_t         tbl [6];
    logic [127:0] sb_q [$];
    int           vectors = 0;
    int           miscompares = 0;
    logic [127:0] samp_pkg;
    logic         samp_valid;
    logic         samp_ready;
    logic [2:0]   samp_count;

    function automatic logic [127:0] ref_pack(input logic [31:0] pc, input logic [63:0] data,
                                              input logic [1:0] br, input logic [1:0] tk);
        logic [127:0] p;
        p          = 128'd0;
        p[127:96]  = pc & 32'hffff_fffc;
        p[31]      = 1'b1;
        if (pc[2]) begin
            p[95:64] = data[63:32];
            p[29]    = br[1];
            p[28]    = br[1] && tk[1];
        end else begin
            p[95:64] = data[31:0];
            p[29]    = br[0];
            p[28]    = br[0] && tk[0];
            if (!p[28]) begin
                p[30]    = 1'b1;
                p[63:32] = data[63:32];
                p[27]    = br[1];
                p[26]    = br[1] && tk[1];
            end
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare outputs at the falling edge against the model, advance the model, then step past the rising edge.
    task automatic cycle();
        logic [127:0] e_pkg;
        logic         e_valid;
        logic         e_ready;
        logic         byp;
        logic         enq;
        int           n;
        @(negedge clk);
        n   = sb_q.size();
        byp = 1'b0;
`ifdef FETCH_PACKER_BYPASS_EN
        byp = rst && fetch_valid_i && !flush_i && (n == 0);
`endif
        e_ready = rst && !flush_i && (n < DEPTH);
        e_valid = rst && ((n != 0) || byp);
        if (rst && n != 0)  e_pkg = sb_q[0];
        else if (byp)       e_pkg = ref_pack(fetch_pc_i, fetch_data_i, pred_br_i, pred_taken_i);
        else                e_pkg = 128'd0;
        chk("fetch_ready", {127'd0, fetch_ready_o}, {127'd0, e_ready});
        chk("package_valid", {127'd0, package_valid_o}, {127'd0, e_valid});
        chk("inst_package", inst_package_o, e_pkg);
        chk("fifo_count", {125'd0, fifo_count_o}, rst ? 128'(n) : 128'd0);
        samp_pkg   = inst_package_o;
        samp_valid = package_valid_o;
        samp_ready = fetch_ready_o;
        samp_count = fifo_count_o;
        if (!rst || flush_i) begin
            sb_q.delete();
        end else begin
            enq = fetch_valid_i && (n < DEPTH) && !(byp && package_ready_i);
            if (n != 0 && package_ready_i) void'(sb_q.pop_front());
            if (enq) sb_q.push_back(ref_pack(fetch_pc_i, fetch_data_i, pred_br_i, pred_taken_i));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] pc, input logic [63:0] data, input logic [1:0] br, input logic [1:0] tk);
        fetch_valid_i = 1'b1;
        fetch_pc_i    = pc;
        fetch_data_i  = data;
        pred_br_i     = br;
        pred_taken_i  = tk;
    endtask

    initial begin
        tbl[0] = '{32'h1c00_0000, 64'h0280_0421_0015_0004, 2'b00, 2'b00, 128'h1c000000_00150004_02800421_c0000000};
        tbl[1] = '{32'h1c00_0004, 64'h0280_0421_0015_0004, 2'b10, 2'b10, 128'h1c000004_02800421_00000000_b0000000};
        tbl[2] = '{32'h1c00_0010, 64'h0280_0421_0015_0004, 2'b11, 2'b01, 128'h1c000010_00150004_00000000_b0000000};
        tbl[3] = '{32'h1c00_0023, 64'hdead_beef_1234_5678, 2'b10, 2'b10, 128'h1c000020_12345678_deadbeef_cc000000};
        tbl[4] = '{32'h0000_0006, 64'hdead_beef_1234_5678, 2'b01, 2'b11, 128'h00000004_deadbeef_00000000_80000000};
        tbl[5] = '{32'h0000_1000, 64'hdead_beef_1234_5678, 2'b01, 2'b00, 128'h00001000_12345678_deadbeef_e0000000};

        rst = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0; package_ready_i = 1'b0;
        fetch_pc_i = 32'd0; fetch_data_i = 64'd0; pred_br_i = 2'b00; pred_taken_i = 2'b00;
        @(posedge clk); #1;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        chk("ready_after_reset", {127'd0, samp_ready}, 128'd1);

        // Hand-computed packages, decode always ready.
        package_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            beat(tbl[i].pc, tbl[i].data, tbl[i].br, tbl[i].tk);
            cycle();
`ifndef FETCH_PACKER_BYPASS_EN
            fetch_valid_i = 1'b0;
            cycle();
`endif
            chk("table_pkg", samp_pkg, tbl[i].exp);
            chk("table_valid", {127'd0, samp_valid}, 128'd1);
            fetch_valid_i = 1'b0;
        end
        cycle();

        // Backpressure: four accepts fill the queue, the fifth beat is held.
        package_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat(32'(k * 8), {32'(k), 32'(k + 100)}, 2'b00, 2'b00);
            cycle();
        end
        beat(32'h20, 64'h0000_0004_0000_0068, 2'b00, 2'b00);
        cycle();
        chk("full_count", {125'd0, samp_count}, 128'd4);
        chk("full_ready", {127'd0, samp_ready}, 128'd0);
        package_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("drain_order", {96'd0, samp_pkg[127:96]}, 128'(k * 8));
            if (k == 1) fetch_valid_i = 1'b0;
        end
        cycle();

        // Flush with three entries while a beat is offered.
        package_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat(32'(k * 8 + 8'h40), 64'h1111_2222_3333_4444, 2'b00, 2'b00);
            cycle();
        end
        flush_i = 1'b1;
        beat(32'h80, 64'h5555_6666_7777_8888, 2'b00, 2'b00);
        cycle();
        flush_i = 1'b0; fetch_valid_i = 1'b0;
        cycle();
        chk("flush_count", {125'd0, samp_count}, 128'd0);
        chk("flush_valid", {127'd0, samp_valid}, 128'd0);
        chk("flush_pkg", samp_pkg, 128'd0);

        // Reset with two buffered entries.
        for (int k = 0; k < 2; k++) begin
            beat(32'(k * 8 + 8'h90), 64'h9999_aaaa_bbbb_cccc, 2'b01, 2'b01);
            cycle();
        end
        rst = 1'b0;
        cycle();
        chk("rst_ready", {127'd0, samp_ready}, 128'd0);
        chk("rst_pkg", samp_pkg, 128'd0);
        rst = 1'b1; fetch_valid_i = 1'b0; package_ready_i = 1'b1;
        cycle();
        chk("post_rst_ready", {127'd0, samp_ready}, 128'd1);
        chk("post_rst_valid", {127'd0, samp_valid}, 128'd0);

        // Sustained throughput with decode always ready.
        for (int k = 0; k < 8; k++) begin
            beat($urandom, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            cycle();
        end
        fetch_valid_i = 1'b0;
        cycle(); cycle();

        // Random traffic to exercise pointer wrap and mixed enqueue/dequeue.
        for (int k = 0; k < 120; k++) begin
            beat($urandom, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            fetch_valid_i   = ($urandom_range(0, 3) != 0);
            package_ready_i = ($urandom_range(0, 2) == 0);
            flush_i         = ($urandom_range(0, 29) == 0);
            cycle();
        end
        flush_i = 1'b0; fetch_valid_i = 1'b0; package_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
